// File: rtl/des_key_schedule.sv
// DES key schedule: PC-1 load, per-round C/D rotation, registered PC-2 subkey output.
// Define DES_KS_DECRYPT_EN to add the i_decrypt port (subkeys delivered K16..K1).
module des_key_schedule (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [63:0] i_key,
`ifdef DES_KS_DECRYPT_EN
    input  logic        i_decrypt,
`endif
    output logic [47:0] o_subkey,
    output logic        o_subkey_valid,
    output logic [3:0]  o_round_idx,
    output logic        o_done
);

    // state | meaning
    // IDLE  | waiting for i_start; C/D loaded from PC-1 on the way out
    // ROUND | one subkey produced per cycle, 16 rounds
    // DONE  | all subkeys delivered; o_done held until i_start drops
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES bit n maps to vector bit (width - n)
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) r[55-i] = k[64-PC1[i]];
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [27:0] c, input logic [27:0] d);
        logic [55:0] cd;
        logic [47:0] r;
        cd = {c, d};
        r  = '0;
        for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
        return r;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_load;
    logic        w_step;
    logic [27:0] r_c;
    logic [27:0] r_d;
    logic [3:0]  r_cnt;
    logic [27:0] w_c_rot;
    logic [27:0] w_d_rot;
    logic [55:0] w_cd_init;
    logic        w_shift_one;
    logic [47:0] r_subkey;
    logic        r_valid;
    logic [3:0]  r_idx;
    logic        r_done;
    logic        w_unused_parity;
`ifdef DES_KS_DECRYPT_EN
    logic        r_dec;
    logic        w_dec_one;
`endif

    assign w_unused_parity = ^{i_key[56], i_key[48], i_key[40], i_key[32],
                               i_key[24], i_key[16], i_key[8],  i_key[0]};
    assign w_cd_init = pc1(i_key);

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = ROUND;
                    w_load      = 1'b1;
                end
            end
            ROUND: begin
                if (!i_start) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == 4'd15) w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (!i_start) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // r_cnt is k-1 for edge Ek; single-bit shifts at rounds 1, 2, 9, 16
    assign w_shift_one = (r_cnt == 4'd0) || (r_cnt == 4'd1) ||
                         (r_cnt == 4'd8) || (r_cnt == 4'd15);
`ifdef DES_KS_DECRYPT_EN
    assign w_dec_one = (r_cnt == 4'd1) || (r_cnt == 4'd8) || (r_cnt == 4'd15);
`endif

    always_comb begin
        w_c_rot = w_shift_one ? {r_c[26:0], r_c[27]}    : {r_c[25:0], r_c[27:26]};
        w_d_rot = w_shift_one ? {r_d[26:0], r_d[27]}    : {r_d[25:0], r_d[27:26]};
`ifdef DES_KS_DECRYPT_EN
        // decrypt walks the schedule backwards; round 1 reuses C0/D0 (= C16/D16)
        if (r_dec) begin
            if (r_cnt == 4'd0) begin
                w_c_rot = r_c;
                w_d_rot = r_d;
            end else if (w_dec_one) begin
                w_c_rot = {r_c[0], r_c[27:1]};
                w_d_rot = {r_d[0], r_d[27:1]};
            end else begin
                w_c_rot = {r_c[1:0], r_c[27:2]};
                w_d_rot = {r_d[1:0], r_d[27:2]};
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c      <= '0;
            r_d      <= '0;
            r_cnt    <= '0;
            r_subkey <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
            r_done   <= 1'b0;
`ifdef DES_KS_DECRYPT_EN
            r_dec    <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_c   <= w_cd_init[55:28];
                r_d   <= w_cd_init[27:0];
                r_cnt <= '0;
`ifdef DES_KS_DECRYPT_EN
                r_dec <= i_decrypt;
`endif
            end
            if (w_step) begin
                r_c      <= w_c_rot;
                r_d      <= w_d_rot;
                r_subkey <= pc2(w_c_rot, w_d_rot);
                r_valid  <= 1'b1;
                r_idx    <= r_cnt;
                r_cnt    <= r_cnt + 4'd1;
            end else if (!i_start) begin
                r_valid <= 1'b0;
                r_done  <= 1'b0;
                r_idx   <= '0;
            end else if (r_state == DONE) begin
                r_valid <= 1'b0;
                r_done  <= 1'b1;
            end
        end
    end

    assign o_subkey       = r_subkey;
    assign o_subkey_valid = r_valid;
    assign o_round_idx    = r_idx;
    assign o_done         = r_done;

endmodule
